// File: rtl/lifetime_histogram_multi_if.sv
// Tag input stream and histogram readout stream of lifetime_histogram_multi.
// slave = histogrammer side, master = tag source / readout consumer side.
interface lifetime_histogram_multi_if #(
  parameter int CHANNEL_WIDTH = 6,
  parameter int COUNT_WIDTH   = 32,
  parameter int BANK_W        = 2,
  parameter int BIN_BITS      = 12
);
  logic                     s_tag_valid;
  logic                     s_tag_ready;
  logic [CHANNEL_WIDTH-1:0] s_tag_channel;
  logic [63:0]              s_tag_time;

  logic                     m_valid;
  logic                     m_ready;
  logic [COUNT_WIDTH-1:0]   m_data;
  logic [BANK_W-1:0]        m_bank;
  logic [BIN_BITS-1:0]      m_bin;
  logic                     m_last;

  modport slave (
    input  s_tag_valid,
    input  s_tag_channel,
    input  s_tag_time,
    output s_tag_ready,
    output m_valid,
    output m_data,
    output m_bank,
    output m_bin,
    output m_last,
    input  m_ready
  );

  modport master (
    output s_tag_valid,
    output s_tag_channel,
    output s_tag_time,
    input  s_tag_ready,
    input  m_valid,
    input  m_data,
    input  m_bank,
    input  m_bin,
    input  m_last,
    output m_ready
  );
endinterface

// File: rtl/lifetime_histogram_multi.sv
// Multi-channel lifetime histogrammer, clear-on-read streaming readout.
// Define LIFETIME_HIST_SATURATE_EN for saturating bin counters (default wraps).
module lifetime_histogram_multi #(
  parameter int CLICKS        = 4,
  parameter int BIN_BITS      = 12,
  parameter int COUNT_WIDTH   = 32,
  parameter int CHANNEL_WIDTH = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  lifetime_histogram_multi_if.slave bus,
  input  logic                     config_en_i,
  input  logic [CHANNEL_WIDTH-1:0] start_channel_i,
  input  logic [CHANNEL_WIDTH-1:0] click_channel_base_i,
  input  logic [5:0]               shift_val_i,
  input  logic                     hist_read_start_i,
  output logic [31:0]              overflow_count_o,
  output logic                     busy_o
);

  localparam int BANK_W = (CLICKS > 1) ? $clog2(CLICKS) : 1;
  localparam int BINS   = 2 ** BIN_BITS;
  localparam int DEPTH  = CLICKS * BINS;
  localparam int AW     = BANK_W + BIN_BITS;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    CLEAR,
    ACCUM,
    DRAIN,
    READ
  } state_t;

  state_t state, state_nx;

  logic [COUNT_WIDTH-1:0] mem [DEPTH];
  logic [COUNT_WIDTH-1:0] rd_q;
  logic [AW-1:0]          raddr;
  logic [AW-1:0]          waddr;
  logic                   we;
  logic [COUNT_WIDTH-1:0] wdata;

  logic [AW-1:0] clr_cnt;
  logic          drain_cnt;
  logic [AW-1:0] rd_ptr;
  logic          m_valid_q;
  logic          handshake;
  logic          tag_ready;

  logic [63:0] start_time;
  logic        start_valid;
  logic        en_q;

  logic                   acc;
  logic                   is_start;
  logic                   in_range;
  logic                   is_click;
  logic                   bin_ovf;
  logic                   hit;
  logic                   ovf_hit;
  logic [CHANNEL_WIDTH:0] offs;
  logic [63:0]            delta;
  logic [63:0]            bin_full;
  logic [AW-1:0]          tag_addr;

  logic                   s1_valid;
  logic [AW-1:0]          s1_addr;
  logic [COUNT_WIDTH-1:0] s1_old;
  logic [COUNT_WIDTH-1:0] s1_new;
  logic                   s2_valid;
  logic [AW-1:0]          s2_addr;
  logic [COUNT_WIDTH-1:0] s2_data;

  // Tag classification, all from inputs at acceptance
  assign acc      = bus.s_tag_valid && tag_ready;
  assign is_start = bus.s_tag_channel == start_channel_i;
  assign offs     = {1'b0, bus.s_tag_channel}
                  - {1'b0, click_channel_base_i};
  assign in_range = !offs[CHANNEL_WIDTH]
                 && (offs < (CHANNEL_WIDTH+1)'(CLICKS));
  assign is_click = acc && config_en_i && !is_start
                 && in_range && start_valid;
  assign delta    = bus.s_tag_time - start_time;
  assign bin_full = delta >> shift_val_i;
  assign bin_ovf  = (bin_full >> BIN_BITS) != 64'd0;
  assign hit      = is_click && !bin_ovf;
  assign ovf_hit  = is_click && bin_ovf;
  assign tag_addr = {BANK_W'(offs), BIN_BITS'(bin_full)};

  // Stage 2 wrote this address on the same edge stage 1 read it
  assign s1_old = (s2_valid && (s2_addr == s1_addr)) ? s2_data : rd_q;

`ifdef LIFETIME_HIST_SATURATE_EN
  assign s1_new = (&s1_old) ? s1_old : s1_old + COUNT_WIDTH'(1);
`else
  assign s1_new = s1_old + COUNT_WIDTH'(1);
`endif

  assign handshake = m_valid_q && bus.m_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      CLEAR: if (clr_cnt == LAST) state_nx = ACCUM;
      ACCUM: if (hist_read_start_i) state_nx = DRAIN;
      DRAIN: if (drain_cnt) state_nx = READ;
      READ:  if (handshake && rd_ptr == LAST) state_nx = ACCUM;
      default: state_nx = CLEAR;
    endcase
  end

  always_comb begin
    tag_ready = 1'b0;
    busy_o    = 1'b1;
    we        = 1'b0;
    waddr     = s1_addr;
    wdata     = s1_new;
    raddr     = tag_addr;
    unique case (state)
      CLEAR: begin
        we    = 1'b1;
        waddr = clr_cnt;
        wdata = '0;
      end
      ACCUM: begin
        tag_ready = 1'b1;
        busy_o    = 1'b0;
        we        = s1_valid;
      end
      DRAIN: begin
        we = s1_valid;
      end
      READ: begin
        we    = handshake;
        waddr = rd_ptr;
        wdata = '0;
        raddr = (handshake && rd_ptr != LAST)
              ? rd_ptr + AW'(1) : rd_ptr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rd_q <= mem[raddr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clr_cnt   <= '0;
      drain_cnt <= 1'b0;
      rd_ptr    <= '0;
      m_valid_q <= 1'b0;
    end else begin
      clr_cnt   <= (state == CLEAR) ? clr_cnt + AW'(1) : '0;
      drain_cnt <= (state == DRAIN) ? !drain_cnt : 1'b0;
      if (state != READ) begin
        m_valid_q <= 1'b0;
        rd_ptr    <= '0;
      end else if (!m_valid_q) begin
        m_valid_q <= 1'b1;
      end else if (bus.m_ready) begin
        if (rd_ptr == LAST) begin
          m_valid_q <= 1'b0;
          rd_ptr    <= '0;
        end else begin
          rd_ptr <= rd_ptr + AW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      start_valid      <= 1'b0;
      start_time       <= '0;
      en_q             <= 1'b0;
      overflow_count_o <= '0;
      s1_valid         <= 1'b0;
      s1_addr          <= '0;
      s2_valid         <= 1'b0;
      s2_addr          <= '0;
      s2_data          <= '0;
    end else begin
      en_q <= config_en_i;
      if (en_q && !config_en_i) begin
        start_valid <= 1'b0;
      end else if (acc && config_en_i && is_start) begin
        start_valid <= 1'b1;
        start_time  <= bus.s_tag_time;
      end
      if (ovf_hit) overflow_count_o <= overflow_count_o + 32'd1;
      s1_valid <= hit;
      s1_addr  <= tag_addr;
      s2_valid <= s1_valid;
      s2_addr  <= s1_addr;
      s2_data  <= s1_new;
    end
  end

  assign bus.s_tag_ready = tag_ready;
  assign bus.m_valid     = m_valid_q;
  assign bus.m_data      = m_valid_q ? rd_q : '0;
  assign bus.m_bank      = rd_ptr[AW-1:BIN_BITS];
  assign bus.m_bin       = rd_ptr[BIN_BITS-1:0];
  assign bus.m_last      = m_valid_q && (rd_ptr == LAST);

endmodule
